// File: rtl/knight_pkg.sv
// Shared definitions for the knight LED display: pattern select codes and the
// sequencer state encoding. Used by the sequencer and the control register block.
package knight_pkg;

  localparam logic [1:0] PAT_OFF    = 2'd0;
  localparam logic [1:0] PAT_BOUNCE = 2'd1;
  localparam logic [1:0] PAT_ROTATE = 2'd2;
  localparam logic [1:0] PAT_FILL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    BOUNCE_UP = 3'd1,
    BOUNCE_DN = 3'd2,
    ROTATE    = 3'd3,
    FILL      = 3'd4
  } knight_state_t;

  // Entry state taken on a pattern restart.
  function automatic knight_state_t entry_state(input logic [1:0] pat);
    knight_state_t st;
    case (pat)
      PAT_BOUNCE: st = BOUNCE_UP;
      PAT_ROTATE: st = ROTATE;
      PAT_FILL:   st = FILL;
      default:    st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/knight_seq_if.sv
// Control/frame bundle between the control register block (master) and the
// knight sequencer (slave).
interface knight_seq_if #(
  parameter int LED_W = 8
);
  logic [1:0]       KNIGHT_PATTERN;
  logic [31:0]      KNIGHT_CDIV;
  logic [LED_W-1:0] LED;
  logic             STEP;

  modport master (
    output KNIGHT_PATTERN,
    output KNIGHT_CDIV,
    input  LED,
    input  STEP
  );

  modport slave (
    input  KNIGHT_PATTERN,
    input  KNIGHT_CDIV,
    output LED,
    output STEP
  );
endinterface

// File: rtl/knight_tick.sv
// Step-tick divider: free-running up-counter compared against cdiv. A lowered
// cdiv below the current count fires on the next edge rather than wrapping.
module knight_tick (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] cdiv,
  output logic        tick
);

  logic [31:0] r_cnt;
  logic        w_hit;

  assign w_hit = (r_cnt >= cdiv);
  assign tick  = en & ~clr & w_hit;

  // Divider counter: cleared on restart, parked at 0 while disabled.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt <= '0;
    end else if (clr || !en) begin
      r_cnt <= '0;
    end else if (w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/knight_seq.sv
// Knight LED frame sequencer: pattern FSM, position/level registers and the
// frame encoder, stepped by knight_tick.
// Build option: KNIGHT_SEQ_TRAIL_EN adds a trailing LED in the bounce patterns.
//
// state     | meaning
// ----------+--------------------------------------------
// IDLE      | pattern OFF, LED dark, divider parked
// BOUNCE_UP | single LED moving toward MSB
// BOUNCE_DN | single LED moving toward LSB
// ROTATE    | single LED moving toward MSB, wraps to LSB
// FILL      | bar of lvl LEDs from LSB, wraps to empty
module knight_seq
  import knight_pkg::*;
#(
  parameter int LED_W = 8
) (
  input logic        ACLK,
  input logic        ARESETN,
  knight_seq_if.slave bus
);

  localparam int POS_W = $clog2(LED_W);
  localparam int LVL_W = $clog2(LED_W + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LED_W);

  knight_state_t    r_state;
  logic [1:0]       r_pat_q;
  logic [POS_W-1:0] r_pos;
  logic [LVL_W-1:0] r_lvl;
  logic [LED_W-1:0] r_led;
  logic             r_step;

  knight_state_t    w_state_nxt;
  logic [POS_W-1:0] w_pos_nxt;
  logic [POS_W-1:0] w_pos_inc;
  logic [POS_W-1:0] w_pos_dec;
  logic [LVL_W-1:0] w_lvl_nxt;
  logic [LED_W-1:0] w_led_nxt;
  logic             w_restart;
  logic             w_tick;
`ifdef KNIGHT_SEQ_TRAIL_EN
  logic [POS_W-1:0] r_prev_pos;
  logic [POS_W-1:0] w_prev_nxt;
`endif

  assign w_restart = (bus.KNIGHT_PATTERN != r_pat_q);
  assign w_pos_inc = r_pos + POS_W'(1);
  assign w_pos_dec = r_pos - POS_W'(1);

  knight_tick u_tick (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clr     (w_restart),
    .en      (r_state != IDLE),
    .cdiv    (bus.KNIGHT_CDIV),
    .tick    (w_tick)
  );

  // Next state/position/level: restart wins over a same-cycle tick.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_lvl_nxt   = r_lvl;
`ifdef KNIGHT_SEQ_TRAIL_EN
    w_prev_nxt  = r_prev_pos;
`endif
    if (w_restart) begin
      w_state_nxt = entry_state(bus.KNIGHT_PATTERN);
      w_pos_nxt   = '0;
      w_lvl_nxt   = '0;
`ifdef KNIGHT_SEQ_TRAIL_EN
      w_prev_nxt  = '0;
`endif
    end else if (w_tick) begin
`ifdef KNIGHT_SEQ_TRAIL_EN
      w_prev_nxt = r_pos;
`endif
      case (r_state)
        BOUNCE_UP: begin
          w_pos_nxt = w_pos_inc;
          if (w_pos_inc == POS_MAX) w_state_nxt = BOUNCE_DN;
        end
        BOUNCE_DN: begin
          w_pos_nxt = w_pos_dec;
          if (w_pos_dec == '0) w_state_nxt = BOUNCE_UP;
        end
        ROTATE: w_pos_nxt = (r_pos == POS_MAX) ? '0 : w_pos_inc;
        FILL:   w_lvl_nxt = (r_lvl == LVL_MAX) ? '0 : r_lvl + LVL_W'(1);
        default: ;
      endcase
    end
  end

  // Frame encoder on the next-state values so LED is a plain register.
  always_comb begin
    w_led_nxt = '0;
    case (w_state_nxt)
      BOUNCE_UP, BOUNCE_DN: begin
        w_led_nxt[w_pos_nxt] = 1'b1;
`ifdef KNIGHT_SEQ_TRAIL_EN
        w_led_nxt[w_prev_nxt] = 1'b1;
`endif
      end
      ROTATE: w_led_nxt[w_pos_nxt] = 1'b1;
      FILL: begin
        // Bit-wise thermometer avoids the overflow of (1<<LED_W)-1.
        for (int i = 0; i < LED_W; i++) begin
          w_led_nxt[i] = (LVL_W'(i) < w_lvl_nxt);
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered frame and step pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= IDLE;
      r_pat_q    <= PAT_OFF;
      r_pos      <= '0;
      r_lvl      <= '0;
      r_led      <= '0;
      r_step     <= 1'b0;
`ifdef KNIGHT_SEQ_TRAIL_EN
      r_prev_pos <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pat_q    <= bus.KNIGHT_PATTERN;
      r_pos      <= w_pos_nxt;
      r_lvl      <= w_lvl_nxt;
      r_led      <= w_led_nxt;
      r_step     <= w_tick;
`ifdef KNIGHT_SEQ_TRAIL_EN
      r_prev_pos <= w_prev_nxt;
`endif
    end
  end

  assign bus.LED  = r_led;
  assign bus.STEP = r_step;

endmodule

// File: tb/tb_knight_seq.sv
// Directed bench for knight_seq (LED_W=8): a vector table for the steady
// patterns plus hand sequences for divider, restart and reset corners.
module tb_knight_seq;

  logic ACLK;
  logic ARESETN;
  int   errors;
  int   checks;

  knight_seq_if #(.LED_W(8)) bus ();

  knight_seq #(.LED_W(8)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  pat;
    logic [31:0] cdiv;
    int          wt;
    logic [7:0]  led;
    logic        step;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [1:0] p, input logic [31:0] c,
                              input int w, input logic [7:0] l, input logic s);
    vec_t v;
    v.pat = p; v.cdiv = c; v.wt = w; v.led = l; v.step = s;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic chk_out(input string name, input logic [7:0] l, input logic s);
    chk({name, " LED"}, {24'd0, bus.LED}, {24'd0, l});
    chk({name, " STEP"}, {31'd0, bus.STEP}, {31'd0, s});
  endtask

  logic [7:0] bounce_exp [15];
  logic [7:0] rot_exp [9];
  logic [7:0] fill_exp [8];
  logic [7:0] pos5_led;

  initial begin
    errors = 0;
    checks = 0;
`ifdef KNIGHT_SEQ_TRAIL_EN
    bounce_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC0,
                   8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h03};
    pos5_led   = 8'h30;
`else
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    pos5_led   = 8'h20;
`endif
    rot_exp  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    fill_exp = '{8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};

    // Bounce, CDIV=3: first frame one cycle after change, then every 4 cycles.
    add(2'd1, 32'd3, 1, 8'h01, 1'b0);
    add(2'd1, 32'd3, 3, 8'h01, 1'b0);
    for (int i = 0; i < 15; i++) add(2'd1, 32'd3, (i == 0) ? 1 : 4, bounce_exp[i], 1'b1);
    // Rotate, CDIV=0: advances every cycle with STEP held high.
    add(2'd2, 32'd0, 1, 8'h01, 1'b0);
    for (int i = 0; i < 9; i++) add(2'd2, 32'd0, 1, rot_exp[i], 1'b1);
    // Fill, CDIV=1: advances every 2 cycles, wraps through 0x00.
    add(2'd3, 32'd1, 1, 8'h00, 1'b0);
    add(2'd3, 32'd1, 2, 8'h01, 1'b1);
    add(2'd3, 32'd1, 1, 8'h01, 1'b0);
    add(2'd3, 32'd1, 1, 8'h03, 1'b1);
    for (int i = 0; i < 8; i++) add(2'd3, 32'd1, 2, fill_exp[i], 1'b1);

    bus.KNIGHT_PATTERN = 2'd0;
    bus.KNIGHT_CDIV    = 32'd0;
    ARESETN = 1'b0;
    #12;
    chk_out("reset", 8'h00, 1'b0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    cyc(2);
    chk_out("idle", 8'h00, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      bus.KNIGHT_PATTERN = vq[i].pat;
      bus.KNIGHT_CDIV    = vq[i].cdiv;
      cyc(vq[i].wt);
      chk_out($sformatf("vec%0d", i), vq[i].led, vq[i].step);
    end

    // Restart from FILL with CDIV=0 must not step on the restart edge.
    bus.KNIGHT_PATTERN = 2'd1;
    bus.KNIGHT_CDIV    = 32'd0;
    cyc(1);
    chk_out("restart_prio", 8'h01, 1'b0);
    cyc(5);
    chk_out("bounce_pos5", pos5_led, 1'b1);
    bus.KNIGHT_CDIV = 32'd100;
    cyc(3);
    chk_out("bounce_hold", pos5_led, 1'b0);

    // Switch to ROTATE, then lower CDIV below the running count.
    bus.KNIGHT_PATTERN = 2'd2;
    cyc(1);
    chk_out("rot_restart", 8'h01, 1'b0);
    bus.KNIGHT_CDIV = 32'd1000;
    cyc(50);
    chk_out("cnt50_hold", 8'h01, 1'b0);
    bus.KNIGHT_CDIV = 32'd2;
    cyc(1);
    chk_out("cdiv_drop", 8'h02, 1'b1);
    cyc(2);
    chk_out("cdiv2_wait", 8'h02, 1'b0);
    cyc(1);
    chk_out("cdiv2_tick", 8'h04, 1'b1);

    // Pattern glitch back to pat_q between edges is ignored.
    bus.KNIGHT_CDIV    = 32'd0;
    bus.KNIGHT_PATTERN = 2'd3;
    #2;
    bus.KNIGHT_PATTERN = 2'd2;
    cyc(1);
    chk_out("glitch", 8'h08, 1'b1);

    // Async reset mid-FILL clears LED before the next edge.
    bus.KNIGHT_PATTERN = 2'd3;
    bus.KNIGHT_CDIV    = 32'd1;
    cyc(1);
    chk_out("fill_restart", 8'h00, 1'b0);
    cyc(6);
    chk_out("fill_lvl3", 8'h07, 1'b1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk_out("async_rst", 8'h00, 1'b0);
    @(negedge ACLK);
    bus.KNIGHT_PATTERN = 2'd1;
    ARESETN = 1'b1;
    cyc(1);
    chk_out("rst_restart", 8'h01, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
